// File: rtl/arr_mp.sv
// Single-port DEPTH x DATA_W array shared by CH round-robin channels and a host port.
// After reset, a zero-clear sweep runs before any access is accepted.
module arr_mp #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = $clog2(DEPTH),
  parameter int CH     = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 controlArr,
  input  logic                 ctrl_we,
  input  logic [ADDR_W-1:0]    ctrl_addr,
  input  logic [DATA_W-1:0]    ctrl_wdata,
  output logic [DATA_W-1:0]    ctrl_rdata,
  output logic                 ctrl_rvalid,
  input  logic [CH-1:0]        ch_req,
  input  logic [CH-1:0]        ch_we,
  input  logic [CH*ADDR_W-1:0] ch_addr,
  input  logic [CH*DATA_W-1:0] ch_wdata,
  output logic [CH-1:0]        ch_gnt,
  output logic [DATA_W-1:0]    ch_rdata,
  output logic [CH-1:0]        ch_rvalid,
  output logic                 ready,
  output logic                 err
);

  localparam int RR_W = (CH > 1) ? $clog2(CH) : 1;
  localparam logic [ADDR_W-1:0] LAST    = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W:0]   DEPTH_X = (ADDR_W + 1)'(DEPTH);

  typedef enum logic {CLEAR, RUN} state_t;

  state_t              r_state, w_state_nx;
  logic [ADDR_W-1:0]   r_cnt;
  logic [RR_W-1:0]     r_rr;
  logic                r_err;
  logic [CH-1:0]       r_ch_rvalid;
  logic                r_ctrl_rvalid;
  logic [DATA_W-1:0]   r_ch_rdata;
  logic [DATA_W-1:0]   r_ctrl_rdata;
  logic [DATA_W-1:0]   r_mem [DEPTH];

  logic                w_found;
  logic [RR_W-1:0]     w_gidx;
  logic [CH-1:0]       w_gnt;
  logic                w_acc;
  logic                w_we;
  logic [ADDR_W-1:0]   w_addr;
  logic [DATA_W-1:0]   w_wdata;
  logic                w_ctrl_rd;
  logic [CH-1:0]       w_ch_rd;
  logic                w_oor;
  logic [DATA_W-1:0]   w_rword;

  // Round-robin search starting at r_rr; host override and the sweep suppress it.
  always_comb begin
    w_found = 1'b0;
    w_gidx  = '0;
    w_gnt   = '0;
    if (r_state == RUN && !controlArr) begin
      for (int k = 0; k < CH; k++) begin
        if (!w_found && ch_req[(int'(r_rr) + k) % CH]) begin
          w_found = 1'b1;
          w_gidx  = RR_W'((int'(r_rr) + k) % CH);
        end
      end
    end
    if (w_found) w_gnt[w_gidx] = 1'b1;
  end

  // Single array port: pick the one access this cycle and the next FSM state.
  always_comb begin
    w_state_nx = r_state;
    w_acc      = 1'b0;
    w_we       = 1'b0;
    w_addr     = r_cnt;
    w_wdata    = '0;
    w_ctrl_rd  = 1'b0;
    w_ch_rd    = '0;
    case (r_state)
      CLEAR: begin
        w_acc = 1'b1;
        w_we  = 1'b1;
        if (r_cnt == LAST) w_state_nx = RUN;
      end
      RUN: begin
        if (controlArr) begin
          w_acc     = 1'b1;
          w_we      = ctrl_we;
          w_addr    = ctrl_addr;
          w_wdata   = ctrl_wdata;
          w_ctrl_rd = !ctrl_we;
        end else if (w_found) begin
          w_acc   = 1'b1;
          w_we    = ch_we[w_gidx];
          w_addr  = ch_addr[int'(w_gidx)*ADDR_W +: ADDR_W];
          w_wdata = ch_wdata[int'(w_gidx)*DATA_W +: DATA_W];
          w_ch_rd = ch_we[w_gidx] ? '0 : w_gnt;
        end
      end
      default: w_state_nx = CLEAR;
    endcase
  end

  assign w_oor   = ({1'b0, w_addr} >= DEPTH_X);
  assign w_rword = w_oor ? '0 : r_mem[w_addr];

  // Array has no reset of its own; the sweep zeroes it, and rst blocks stray writes.
  always_ff @(posedge clk) begin
    if (!rst && w_acc && w_we && !w_oor) r_mem[w_addr] <= w_wdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= CLEAR;
      r_cnt         <= '0;
      r_rr          <= '0;
      r_err         <= 1'b0;
      r_ch_rvalid   <= '0;
      r_ctrl_rvalid <= 1'b0;
      r_ch_rdata    <= '0;
      r_ctrl_rdata  <= '0;
    end else begin
      r_state <= w_state_nx;
      if (r_state == CLEAR) r_cnt <= (r_cnt == LAST) ? '0 : r_cnt + 1'b1;
      if (w_found) r_rr <= RR_W'((int'(w_gidx) + 1) % CH);
      if (w_acc && w_oor) r_err <= 1'b1;
      r_ch_rvalid   <= w_ch_rd;
      r_ctrl_rvalid <= w_ctrl_rd;
      if (|w_ch_rd) r_ch_rdata   <= w_rword;
      if (w_ctrl_rd) r_ctrl_rdata <= w_rword;
    end
  end

  assign ch_gnt      = w_gnt;
  assign ch_rdata    = r_ch_rdata;
  assign ch_rvalid   = r_ch_rvalid;
  assign ctrl_rdata  = r_ctrl_rdata;
  assign ctrl_rvalid = r_ctrl_rvalid;
  assign ready       = (r_state == RUN);
  assign err         = r_err;

endmodule

// File: tb/tb_arr_mp.sv
// Scoreboarded random bench for arr_mp: a plain array/queue model predicts grants,
// read data and flags; a separate monitor checks every valid the DUT presents.
module tb_arr_mp;
  localparam int DATA_W = 8;
  localparam int DEPTH  = 12;
  localparam int CH     = 2;
  localparam int ADDR_W = $clog2(DEPTH);

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                 rst, controlArr, ctrl_we;
  logic [ADDR_W-1:0]    ctrl_addr;
  logic [DATA_W-1:0]    ctrl_wdata, ctrl_rdata, ch_rdata;
  logic                 ctrl_rvalid, ready, err;
  logic [CH-1:0]        ch_req, ch_we, ch_gnt, ch_rvalid;
  logic [CH*ADDR_W-1:0] ch_addr;
  logic [CH*DATA_W-1:0] ch_wdata;

  arr_mp #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W), .CH(CH)) dut (
    .clk(clk), .rst(rst), .controlArr(controlArr), .ctrl_we(ctrl_we),
    .ctrl_addr(ctrl_addr), .ctrl_wdata(ctrl_wdata), .ctrl_rdata(ctrl_rdata),
    .ctrl_rvalid(ctrl_rvalid), .ch_req(ch_req), .ch_we(ch_we), .ch_addr(ch_addr),
    .ch_wdata(ch_wdata), .ch_gnt(ch_gnt), .ch_rdata(ch_rdata), .ch_rvalid(ch_rvalid),
    .ready(ready), .err(err)
  );

  typedef struct {int due; int ch; logic [DATA_W-1:0] d;} exp_t;
  exp_t ctrl_q[$];
  exp_t ch_q[$];

  int n_chk = 0, n_pass = 0, cyc = 0;
  bit armed = 0;
  logic [DATA_W-1:0] last_ch = '0, last_ctrl = '0;

  logic [DATA_W-1:0] m_mem [DEPTH];
  int m_rr = 0, m_sweep = 0;
  bit m_err = 0;

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
  endtask

  always @(posedge clk) begin
    cyc++;
    if (rst) begin
      armed = 1;
      last_ch = '0;
      last_ctrl = '0;
    end
  end

  // Monitor: pops expectations whenever the DUT presents read data.
  always @(negedge clk) begin
    exp_t e;
    if (armed) begin
      while (ctrl_q.size() > 0 && ctrl_q[0].due < cyc) begin
        e = ctrl_q.pop_front();
        n_chk++;
        $display("FAIL ctrl_rvalid_missing: got no valid expected data %0h at cycle %0d", e.d, e.due);
      end
      while (ch_q.size() > 0 && ch_q[0].due < cyc) begin
        e = ch_q.pop_front();
        n_chk++;
        $display("FAIL ch_rvalid_missing: got no valid expected ch%0d data %0h at cycle %0d", e.ch, e.d, e.due);
      end
      if (ctrl_rvalid === 1'b1) begin
        if (ctrl_q.size() == 0) chk("ctrl_rvalid_unexpected", 64'(ctrl_rvalid), 64'(0));
        else begin
          e = ctrl_q.pop_front();
          chk("ctrl_rdata", 64'(ctrl_rdata), 64'(e.d));
          last_ctrl = e.d;
        end
      end else begin
        chk("ctrl_rvalid_low", 64'(ctrl_rvalid), 64'(0));
        chk("ctrl_rdata_hold", 64'(ctrl_rdata), 64'(last_ctrl));
      end
      if (ch_rvalid !== '0) begin
        if (ch_q.size() == 0) chk("ch_rvalid_unexpected", 64'(ch_rvalid), 64'(0));
        else begin
          e = ch_q.pop_front();
          chk("ch_rvalid_onehot", 64'(ch_rvalid), 64'(1) << e.ch);
          chk("ch_rdata", 64'(ch_rdata), 64'(e.d));
          last_ch = e.d;
        end
      end else begin
        chk("ch_rdata_hold", 64'(ch_rdata), 64'(last_ch));
      end
    end
  end

  task automatic access(int who, bit we, int a, logic [DATA_W-1:0] wd);
    exp_t e;
    bit oor;
    oor = (a >= DEPTH);
    if (oor) m_err = 1;
    if (we) begin
      if (!oor) m_mem[a] = wd;
    end else begin
      e.due = cyc + 1;
      e.ch  = who;
      e.d   = oor ? '0 : m_mem[a];
      if (who < 0) ctrl_q.push_back(e);
      else ch_q.push_back(e);
    end
  endtask

  // One clock: inputs already set; predict and check this cycle at the negedge.
  task automatic step();
    int g;
    logic [CH-1:0] eg;
    @(negedge clk);
    if (rst) begin
      m_sweep = DEPTH;
      m_rr = 0;
      m_err = 0;
      foreach (m_mem[i]) m_mem[i] = '0;
    end else begin
      chk("err", 64'(err), 64'(m_err));
      if (m_sweep > 0) begin
        chk("ready_in_clear", 64'(ready), 64'(0));
        chk("gnt_in_clear", 64'(ch_gnt), 64'(0));
        m_sweep--;
      end else begin
        chk("ready", 64'(ready), 64'(1));
        if (controlArr) begin
          chk("gnt_host_override", 64'(ch_gnt), 64'(0));
          access(-1, ctrl_we, int'(ctrl_addr), ctrl_wdata);
        end else begin
          g = -1;
          for (int k = 0; k < CH; k++)
            if (g < 0 && ch_req[(m_rr + k) % CH]) g = (m_rr + k) % CH;
          eg = '0;
          if (g >= 0) eg[g] = 1'b1;
          chk("gnt", 64'(ch_gnt), 64'(eg));
          if (g >= 0) begin
            m_rr = (g + 1) % CH;
            access(g, ch_we[g], int'(ch_addr[g*ADDR_W +: ADDR_W]), ch_wdata[g*DATA_W +: DATA_W]);
          end
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    controlArr = 0; ctrl_we = 0; ctrl_addr = '0; ctrl_wdata = '0;
    ch_req = '0; ch_we = '0; ch_addr = '0; ch_wdata = '0;
  endtask

  task automatic chan(int i, bit we, int a, int wd);
    ch_req[i] = 1'b1;
    ch_we[i]  = we;
    ch_addr[i*ADDR_W +: ADDR_W]  = ADDR_W'(a);
    ch_wdata[i*DATA_W +: DATA_W] = DATA_W'(wd);
  endtask

  initial begin
    idle_in();
    rst = 1;
    step(); step();
    rst = 0;
    // Host and channels try to act during the sweep; both must be ignored.
    controlArr = 1; ctrl_we = 1; ctrl_addr = 3; ctrl_wdata = 8'hFF; ch_req = '1;
    repeat (DEPTH) step();
    idle_in(); controlArr = 1;
    for (int a = 0; a < DEPTH; a++) begin
      ctrl_addr = ADDR_W'(a);
      step();
    end
    // Host write then read-back while both channels request.
    ch_req = '1; ctrl_we = 1; ctrl_addr = 3; ctrl_wdata = 8'hA5; step();
    ctrl_we = 0; step();
    // Both channels hold reads: grants alternate starting at channel 0.
    idle_in(); chan(0, 0, 3, 0); chan(1, 0, 5, 0);
    repeat (4) step();
    idle_in(); chan(1, 1, 7, 8'h3C); step();
    idle_in(); chan(0, 0, 7, 0); step();
    // Out-of-range write then read: dropped, reads 0, err sticky.
    idle_in(); chan(0, 1, 13, 8'h55); step();
    idle_in(); chan(0, 0, 13, 0); step();
    idle_in(); repeat (2) step();
    rst = 1; step(); rst = 0;
    repeat (5) step();
    rst = 1; step(); rst = 0;
    repeat (DEPTH + 2) step();
    // Reset arriving with a channel read pending.
    chan(0, 0, 2, 0); rst = 1; step(); rst = 0;
    idle_in(); repeat (DEPTH + 2) step();
    for (int n = 0; n < 500; n++) begin
      rst = ($urandom_range(0, 99) < 2);
      controlArr = ($urandom_range(0, 3) == 0);
      ctrl_we = 1'($urandom);
      ctrl_addr = ADDR_W'($urandom_range(0, 2**ADDR_W - 1));
      ctrl_wdata = DATA_W'($urandom);
      ch_req = CH'($urandom);
      ch_we = CH'($urandom);
      for (int i = 0; i < CH; i++) begin
        ch_addr[i*ADDR_W +: ADDR_W] = ADDR_W'($urandom_range(0, 2**ADDR_W - 1));
        ch_wdata[i*DATA_W +: DATA_W] = DATA_W'($urandom);
      end
      step();
    end
    rst = 0; idle_in(); repeat (3) step();
    chk("ctrl_q_drained", 64'(ctrl_q.size()), 64'(0));
    chk("ch_q_drained", 64'(ch_q.size()), 64'(0));
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
